// File: rtl/pwm_capture_pkg.sv
// Shared constants for the pwm_capture peripheral: register map and CTRL/STATUS bit layout.
package pwm_capture_pkg;

    // Register addresses on the peripheral bus
    localparam logic [1:0] ADDR_HIGH   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // CTRL/STATUS bit positions
    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_VALID = 1;
    localparam int unsigned CTRL_OVF   = 2;

endpackage

// File: rtl/pwm_capture_if.sv
// Simple chip-select/write-enable peripheral bus shared with the PWM generator.
// Read data is named dout because "do" is a reserved word.
interface pwm_capture_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cs;
    logic             wren;
    logic [1:0]       addr;
    logic [WIDTH-1:0] di;
    logic [WIDTH-1:0] dout;

    modport master (output cs, output wren, output addr, output di, input dout);
    modport slave  (input cs, input wren, input addr, input di, output dout);
endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer plus a previous-value flop; emits one-cycle rise/fall pulses.
// Both edges see the same latency, so interval measurements are unaffected.
module sync_edge (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic sync1_q, sync2_q, prev_q;

    // Synchronizer chain and edge-history flop
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;
endmodule

// File: rtl/pwm_capture.sv
// Input-capture peripheral: measures high time and period of an external pulse train in
// sys_clk cycles and exposes them on the peripheral bus.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           pin,
    pwm_capture_if.slave   bus
);
    logic             rise, fall;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] high_tmp_q, high_tmp_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             en_q, en_d;
    logic             armed_q, armed_d;
    logic             hi_seen_q, hi_seen_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             ctrl_wr;
    logic             sat;
    logic [WIDTH-1:0] rdata;
    logic             unused_di;

    assign unused_di = ^bus.di[WIDTH-1:3];

    sync_edge u_sync_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (pin),
        .rise      (rise),
        .fall      (fall)
    );

    assign ctrl_wr = bus.cs & bus.wren & (bus.addr == ADDR_CTRL);
    assign sat     = &cnt_q;

    // Next-state: control writes, counter, arming and capture
    always_comb begin
        cnt_d      = cnt_q;
        high_tmp_d = high_tmp_q;
        high_d     = high_q;
        period_d   = period_q;
        en_d       = en_q;
        armed_d    = armed_q;
        hi_seen_d  = hi_seen_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;

        if (ctrl_wr) begin
            en_d = bus.di[CTRL_EN];
            if (bus.di[CTRL_VALID]) valid_d = 1'b0;
            if (bus.di[CTRL_OVF])   ovf_d   = 1'b0;
        end

        if (!en_q || !en_d) begin
            // Disabled (or being disabled): drop measurement state, keep results
            armed_d   = 1'b0;
            cnt_d     = '0;
            hi_seen_d = 1'b0;
        end else begin
            // Hardware sets come after the W1C clears so set wins
            if (armed_q && sat) ovf_d = 1'b1;
            if (rise) begin
                cnt_d     = {{(WIDTH-1){1'b0}}, 1'b1};
                hi_seen_d = 1'b0;
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (!sat && hi_seen_q) begin
                    period_d = cnt_q;
                    high_d   = high_tmp_q;
                    valid_d  = 1'b1;
                end
            end else begin
                if (fall && armed_q && !sat) begin
                    high_tmp_d = cnt_q;
                    hi_seen_d  = 1'b1;
                end
                if (armed_q && !sat) cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= '0;
            high_tmp_q <= '0;
            high_q     <= '0;
            period_q   <= '0;
            en_q       <= 1'b0;
            armed_q    <= 1'b0;
            hi_seen_q  <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            high_q     <= high_d;
            period_q   <= period_d;
            en_q       <= en_d;
            armed_q    <= armed_d;
            hi_seen_q  <= hi_seen_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // Combinational read mux, zero when not selected
    always_comb begin
        rdata = '0;
        if (bus.cs) begin
            case (bus.addr)
                ADDR_HIGH:   rdata = high_q;
                ADDR_PERIOD: rdata = period_q;
                ADDR_CTRL: begin
                    rdata[CTRL_EN]    = en_q;
                    rdata[CTRL_VALID] = valid_q;
                    rdata[CTRL_OVF]   = ovf_q;
                end
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.dout = rdata;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture (WIDTH=8 so counter saturation is reachable quickly).
module tb_pwm_capture;
    import pwm_capture_pkg::*;

    localparam int unsigned W = 8;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic pin       = 1'b0;

    always #5 sys_clk = ~sys_clk;

    pwm_capture_if #(.WIDTH(W)) bus ();

    pwm_capture #(.WIDTH(W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pin       (pin),
        .bus       (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic [W-1:0] exp;
    } exp_t;

    typedef struct {
        string        name;
        logic         cs;
        logic [1:0]   addr;
        logic [W-1:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    // Pop the oldest expectation and compare it with the current read data
    task automatic compare_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expectation queued, got %0h", bus.dout);
        end else begin
            e = sb.pop_front();
            if (bus.dout !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0h required %0h", e.name, bus.dout, e.exp);
            end
        end
    endtask

    // Combinational read: costs 1 ns, no clock edge consumed
    task automatic rd(input logic cs, input logic [1:0] addr, input logic [W-1:0] exp,
                      input string name);
        exp_t e;
        bus.cs   = cs;
        bus.wren = 1'b0;
        bus.addr = addr;
        e.name   = name;
        e.exp    = exp;
        sb.push_back(e);
        #1;
        compare_out();
        bus.cs = 1'b0;
    endtask

    // One-cycle bus write
    task automatic wr(input logic [1:0] addr, input logic [W-1:0] data);
        bus.cs   = 1'b1;
        bus.wren = 1'b1;
        bus.addr = addr;
        bus.di   = data;
        @(negedge sys_clk);
        bus.cs   = 1'b0;
        bus.wren = 1'b0;
    endtask

    task automatic pin_for(input logic v, input int n);
        pin = v;
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        bus.cs   = 1'b0;
        bus.wren = 1'b0;
        bus.addr = 2'd0;
        bus.di   = '0;

        vecs[0] = '{"rst_high",   1'b1, ADDR_HIGH,   8'h00};
        vecs[1] = '{"rst_period", 1'b1, ADDR_PERIOD, 8'h00};
        vecs[2] = '{"rst_ctrl",   1'b1, ADDR_CTRL,   8'h00};
        vecs[3] = '{"rst_rsvd",   1'b1, 2'd3,        8'h00};
        vecs[4] = '{"nocs_a0",    1'b0, 2'd0,        8'h00};
        vecs[5] = '{"nocs_a1",    1'b0, 2'd1,        8'h00};
        vecs[6] = '{"nocs_a2",    1'b0, 2'd2,        8'h00};
        vecs[7] = '{"nocs_a3",    1'b0, 2'd3,        8'h00};

        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            rd(vecs[i].cs, vecs[i].addr, vecs[i].exp, vecs[i].name);
        end
        @(negedge sys_clk);

        // 30/100 waveform; captures happen on the 2nd rise onwards
        wr(ADDR_CTRL, 8'h01);
        for (int p = 0; p < 3; p++) begin
            pin_for(1'b1, 30);
            pin_for(1'b0, 70);
        end
        pin_for(1'b1, 5);
        rd(1'b1, ADDR_HIGH,   8'd30,  "high_30");
        rd(1'b1, ADDR_PERIOD, 8'd100, "period_100");
        rd(1'b1, ADDR_CTRL,   8'h03,  "ctrl_valid");
        rd(1'b0, ADDR_HIGH,   8'h00,  "nocs_loaded");
        wr(ADDR_CTRL, 8'h03);
        rd(1'b1, ADDR_CTRL,   8'h01,  "valid_w1c");
        pin_for(1'b1, 24);
        pin_for(1'b0, 70);
        pin_for(1'b1, 5);
        rd(1'b1, ADDR_CTRL,   8'h03,  "valid_again");
        rd(1'b1, ADDR_HIGH,   8'd30,  "high_30b");
        rd(1'b1, ADDR_PERIOD, 8'd100, "period_100b");

        // Minimum 1-cycle high / 1-cycle low
        pin_for(1'b0, 10);
        pin_for(1'b1, 1);
        pin_for(1'b0, 1);
        pin_for(1'b1, 5);
        rd(1'b1, ADDR_HIGH,   8'd1, "high_min");
        rd(1'b1, ADDR_PERIOD, 8'd2, "period_min");

        // Overflow: long low time saturates the counter, no capture
        wr(ADDR_CTRL, 8'h03);
        pin_for(1'b0, 300);
        rd(1'b1, ADDR_CTRL,   8'h05, "ovf_set");
        rd(1'b1, ADDR_HIGH,   8'd1,  "high_kept_ovf");
        rd(1'b1, ADDR_PERIOD, 8'd2,  "period_kept_ovf");
        pin_for(1'b1, 5);
        rd(1'b1, ADDR_CTRL,   8'h05, "no_cap_sat_rise");
        pin_for(1'b1, 5);
        pin_for(1'b0, 20);
        pin_for(1'b1, 5);
        rd(1'b1, ADDR_HIGH,   8'd10, "high_recover");
        rd(1'b1, ADDR_PERIOD, 8'd30, "period_recover");
        rd(1'b1, ADDR_CTRL,   8'h07, "ctrl_recover");
        wr(ADDR_CTRL, 8'h05);
        rd(1'b1, ADDR_CTRL,   8'h03, "ovf_w1c");

        // Disable mid-period, toggle while disabled, re-enable with early fall
        wr(ADDR_CTRL, 8'h02);
        rd(1'b1, ADDR_CTRL,   8'h00, "disabled");
        pin_for(1'b0, 5);
        pin_for(1'b1, 5);
        pin_for(1'b0, 5);
        pin_for(1'b1, 5);
        rd(1'b1, ADDR_HIGH,   8'd10, "high_kept_dis");
        rd(1'b1, ADDR_PERIOD, 8'd30, "period_kept_dis");
        wr(ADDR_CTRL, 8'h01);
        pin_for(1'b0, 15);
        rd(1'b1, ADDR_CTRL,   8'h01, "fall_before_arm");
        pin_for(1'b1, 7);
        rd(1'b1, ADDR_CTRL,   8'h01, "arm_no_cap");
        rd(1'b1, ADDR_HIGH,   8'd10, "high_kept_arm");
        pin_for(1'b0, 13);
        pin_for(1'b1, 5);
        rd(1'b1, ADDR_HIGH,   8'd7,  "high_rearm");
        rd(1'b1, ADDR_PERIOD, 8'd20, "period_rearm");
        rd(1'b1, ADDR_CTRL,   8'h03, "ctrl_rearm");

        // W1C of valid landing on the capture edge: set wins
        wr(ADDR_CTRL, 8'h03);
        rd(1'b1, ADDR_CTRL,   8'h01, "valid_clr_pre");
        pin_for(1'b0, 10);
        pin = 1'b1;
        repeat (2) @(negedge sys_clk);
        wr(ADDR_CTRL, 8'h03);
        rd(1'b1, ADDR_CTRL,   8'h03, "set_wins");

        // Asynchronous reset mid-count, checked before the next clock edge
        pin_for(1'b1, 10);
        #1 sys_rst_n = 1'b0;
        rd(1'b1, ADDR_HIGH,   8'h00, "async_rst_high");
        rd(1'b1, ADDR_PERIOD, 8'h00, "async_rst_period");
        rd(1'b1, ADDR_CTRL,   8'h00, "async_rst_ctrl");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
